hyperram_csr_ctrl: RTL and testbench

Control/status register bank controller for the HyperRAM Wishbone bridge. It holds NUM_REGS 32-bit configuration registers (timing, latency, mode) and shares them between two requesters: the Wishbone slave port, used by software, and an internal hardware update port, used by the HyperRAM PHY/FSM to post status such as the ID-read latency. A small FSM arbitrates between the two ports round-robin, sequences one access at a time and exports the register contents as flat vectors to the datapath.

---
 rtl/hyperram_csr_ctrl.sv | 128 ++++++++++++
 tb/tb_hyperram_csr_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/hyperram_csr_ctrl.sv
// CSR bank for the HyperRAM Wishbone bridge: NUM_REGS x 32-bit registers shared
// between the Wishbone slave and a hardware update port, with round-robin arbitration.
module hyperram_csr_ctrl #(
    parameter int                       NUM_REGS = 4,
    parameter logic [NUM_REGS*32-1:0]   DEFAULTS = '0,
    parameter logic [NUM_REGS-1:0]      RO_MASK  = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_we_i,
    input  logic [3:0]               wb_adr_i,
    input  logic [3:0]               wb_sel_i,
    input  logic [31:0]              wb_dat_i,
    output logic [31:0]              wb_dat_o,
    output logic                     wb_ack_o,
    output logic                     wb_err_o,
    input  logic                     hw_req,
    input  logic [3:0]               hw_idx,
    input  logic [31:0]              hw_data,
    output logic                     hw_gnt,
    output logic [NUM_REGS*32-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      reg_wr
);

    // state  | meaning
    // IDLE   | waiting for a request; the granted access executes on leaving
    // WB_RSP | one-cycle Wishbone ack/err response
    // HW_RSP | one-cycle hw_gnt pulse
    typedef enum logic [1:0] {IDLE, WB_RSP, HW_RSP} state_t;

    state_t      state, state_nxt;
    logic        last_hw;
    logic        err_q;
    logic        wb_pend, grant_wb, grant_hw, wb_hit;
    logic [31:0] rd_data;
    logic [31:0] regs   [NUM_REGS];
    logic [31:0] wr_val [NUM_REGS];
    logic [NUM_REGS-1:0] wr_en;

    assign wb_pend  = wb_cyc_i & wb_stb_i;
    // On a tie the port that was not served last wins.
    assign grant_wb = (state == IDLE) & wb_pend & (~hw_req | last_hw);
    assign grant_hw = (state == IDLE) & hw_req  & (~wb_pend | ~last_hw);

    always_comb begin
        wb_hit  = 1'b0;
        rd_data = '0;
        wr_en   = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_val[i] = regs[i];
            if (wb_adr_i == 4'(i)) begin
                wb_hit  = 1'b1;
                rd_data = regs[i];
                if (grant_wb && wb_we_i && !RO_MASK[i] && (|wb_sel_i)) begin
                    wr_en[i] = 1'b1;
                    for (int b = 0; b < 4; b++)
                        if (wb_sel_i[b]) wr_val[i][8*b +: 8] = wb_dat_i[8*b +: 8];
                end
            end
            if (grant_hw && (hw_idx == 4'(i))) begin
                wr_en[i]  = 1'b1;
                wr_val[i] = hw_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_hw)      state_nxt = HW_RSP;
                else if (grant_wb) state_nxt = WB_RSP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ack/err are masked by cyc so an abandoned cycle sees no response.
    always_comb begin
        wb_ack_o = 1'b0;
        wb_err_o = 1'b0;
        hw_gnt   = 1'b0;
        case (state)
            WB_RSP: begin
                wb_ack_o = wb_cyc_i & ~err_q;
                wb_err_o = wb_cyc_i &  err_q;
            end
            HW_RSP:  hw_gnt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_hw  <= 1'b0;
            err_q    <= 1'b0;
            wb_dat_o <= '0;
            reg_wr   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= DEFAULTS[32*i +: 32];
        end else begin
            reg_wr <= wr_en;
            for (int i = 0; i < NUM_REGS; i++)
                if (wr_en[i]) regs[i] <= wr_val[i];
            if (grant_hw) last_hw <= 1'b1;
            if (grant_wb) begin
                last_hw <= 1'b0;
                err_q   <= ~wb_hit;
                if (!wb_hit)       wb_dat_o <= '0;
                else if (!wb_we_i) wb_dat_o <= rd_data;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
        assign reg_q[32*g +: 32] = regs[g];
    end

endmodule

// File: tb/tb_hyperram_csr_ctrl.sv
// Self-checking bench for hyperram_csr_ctrl: transaction-level register model
// checked every cycle, plus directed arbitration, RO, range and reset cases.
module tb_hyperram_csr_ctrl;

    localparam int             N   = 4;
    localparam logic [127:0]   DEF = {32'hC0DE_0003, 32'h0000_0000, 32'h0000_0000, 32'hDEAD_0000};
    localparam logic [3:0]     RO  = 4'b1000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wb_cyc_i, wb_stb_i, wb_we_i;
    logic [3:0]   wb_adr_i, wb_sel_i;
    logic [31:0]  wb_dat_i, wb_dat_o;
    logic         wb_ack_o, wb_err_o;
    logic         hw_req;
    logic [3:0]   hw_idx;
    logic [31:0]  hw_data;
    logic         hw_gnt;
    logic [127:0] reg_q;
    logic [3:0]   reg_wr;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_regs [N];
    logic [3:0]  exp_wr;
    logic [31:0] exp_dat;

    hyperram_csr_ctrl #(.NUM_REGS(N), .DEFAULTS(DEF), .RO_MASK(RO)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .hw_req(hw_req), .hw_idx(hw_idx), .hw_data(hw_data), .hw_gnt(hw_gnt),
        .reg_q(reg_q), .reg_wr(reg_wr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] model_packed();
        logic [127:0] v;
        for (int i = 0; i < N; i++) v[32*i +: 32] = m_regs[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_regs[i] = DEF[32*i +: 32];
        exp_wr  = '0;
        exp_dat = '0;
    endtask

    // Effect of a Wishbone access, applied in its response cycle.
    task automatic model_wb(input logic we, input logic [3:0] adr, input logic [3:0] sel,
                            input logic [31:0] dat);
        logic [31:0] v;
        if (adr >= 4'(N)) begin
            exp_dat = '0;
        end else if (!we) begin
            exp_dat = m_regs[adr[1:0]];
        end else if (!RO[adr[1:0]] && sel != 4'b0) begin
            v = m_regs[adr[1:0]];
            for (int b = 0; b < 4; b++)
                if (sel[b]) v[8*b +: 8] = dat[8*b +: 8];
            m_regs[adr[1:0]] = v;
            exp_wr = 4'b0001 << adr[1:0];
        end
    endtask

    task automatic model_hw(input logic [3:0] idx, input logic [31:0] dat);
        if (idx < 4'(N)) begin
            m_regs[idx[1:0]] = dat;
            exp_wr = 4'b0001 << idx[1:0];
        end
    endtask

    always @(negedge clk) begin
        chk("reg_q", reg_q, model_packed());
        chk("reg_wr", {124'b0, reg_wr}, {124'b0, exp_wr});
        chk("wb_dat_o", {96'b0, wb_dat_o}, {96'b0, exp_dat});
    end

    task automatic drive_wb(input logic we, input logic [3:0] adr, input logic [3:0] sel,
                            input logic [31:0] dat);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr;  wb_sel_i = sel;  wb_dat_i = dat;
    endtask

    task automatic drop_wb();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic drive_hw(input logic [3:0] idx, input logic [31:0] dat);
        hw_req = 1'b1; hw_idx = idx; hw_data = dat;
    endtask

    // All access tasks start and end 1 ns after a rising edge with the FSM idle.
    task automatic wb_access(input logic we, input logic [3:0] adr, input logic [3:0] sel,
                             input logic [31:0] dat);
        logic inr;
        inr = (adr < 4'(N));
        drive_wb(we, adr, sel, dat);
        @(posedge clk); #1;
        model_wb(we, adr, sel, dat);
        chk("wb_ack", {127'b0, wb_ack_o}, {127'b0, inr});
        chk("wb_err", {127'b0, wb_err_o}, {127'b0, !inr});
        chk("gnt_during_wb", {127'b0, hw_gnt}, 128'd0);
        drop_wb();
        @(posedge clk); #1;
        exp_wr = '0;
        chk("wb_ack_1cycle", {126'b0, wb_ack_o, wb_err_o}, 128'd0);
    endtask

    task automatic hw_access(input logic [3:0] idx, input logic [31:0] dat);
        drive_hw(idx, dat);
        @(posedge clk); #1;
        model_hw(idx, dat);
        chk("hw_gnt", {127'b0, hw_gnt}, 128'd1);
        hw_req = 1'b0;
        @(posedge clk); #1;
        exp_wr = '0;
        chk("hw_gnt_1cycle", {127'b0, hw_gnt}, 128'd0);
    endtask

    // Both ports request on the same cycle; hw_first is the expected winner.
    task automatic tie(input logic hw_first, input logic [3:0] adr, input logic [31:0] wdat,
                       input logic [3:0] idx, input logic [31:0] hdat);
        drive_wb(1'b1, adr, 4'hF, wdat);
        drive_hw(idx, hdat);
        @(posedge clk); #1;
        if (hw_first) begin
            chk("tie1_gnt", {127'b0, hw_gnt}, 128'd1);
            chk("tie1_ack", {127'b0, wb_ack_o}, 128'd0);
            model_hw(idx, hdat);
            hw_req = 1'b0;
        end else begin
            chk("tie1_ack", {127'b0, wb_ack_o}, 128'd1);
            chk("tie1_gnt", {127'b0, hw_gnt}, 128'd0);
            model_wb(1'b1, adr, 4'hF, wdat);
            drop_wb();
        end
        @(posedge clk); #1;
        exp_wr = '0;
        chk("tie_gap", {126'b0, wb_ack_o, hw_gnt}, 128'd0);
        @(posedge clk); #1;
        if (hw_first) begin
            chk("tie2_ack", {127'b0, wb_ack_o}, 128'd1);
            model_wb(1'b1, adr, 4'hF, wdat);
            drop_wb();
        end else begin
            chk("tie2_gnt", {127'b0, hw_gnt}, 128'd1);
            model_hw(idx, hdat);
            hw_req = 1'b0;
        end
        @(posedge clk); #1;
        exp_wr = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = '0; wb_sel_i = '0; wb_dat_i = '0;
        hw_req = 1'b0; hw_idx = '0; hw_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst_outputs", {125'b0, wb_ack_o, wb_err_o, hw_gnt}, 128'd0);
        chk("rst_reg_q", reg_q, {32'hC0DE_0003, 32'h0, 32'h0, 32'hDEAD_0000});

        for (int a = 0; a < N; a++) wb_access(1'b0, 4'(a), 4'hF, 32'h0);
        wb_access(1'b0, 4'd0, 4'hF, 32'h0);
        chk("read0_literal", {96'b0, wb_dat_o}, {96'b0, 32'hDEAD_0000});

        wb_access(1'b1, 4'd1, 4'b0101, 32'hA5A5_1234);
        chk("sel0101_literal", {96'b0, reg_q[63:32]}, {96'b0, 32'h00A5_0034});
        wb_access(1'b0, 4'd1, 4'hF, 32'h0);
        chk("readback1_literal", {96'b0, wb_dat_o}, {96'b0, 32'h00A5_0034});
        wb_access(1'b1, 4'd1, 4'b0000, 32'hFFFF_FFFF);

        tie(1'b1, 4'd2, 32'h11, 4'd2, 32'h22);
        chk("tie_final_literal", {96'b0, reg_q[95:64]}, {96'b0, 32'h11});
        tie(1'b1, 4'd2, 32'h44, 4'd1, 32'h33);
        hw_access(4'd0, 32'h0000_AAAA);
        tie(1'b0, 4'd0, 32'h5555_0000, 4'd2, 32'h66);

        wb_access(1'b1, 4'd3, 4'hF, 32'hFFFF_FFFF);
        hw_access(4'd3, 32'h5);
        chk("ro_hw_literal", {96'b0, reg_q[127:96]}, {96'b0, 32'h5});

        wb_access(1'b0, 4'd9, 4'hF, 32'h0);
        wb_access(1'b1, 4'd9, 4'hF, 32'h1234_5678);
        hw_access(4'd9, 32'hBEEF);
        wb_access(1'b0, 4'd2, 4'hF, 32'h0);

        // Reset asserted mid-cycle while a write is being acknowledged.
        drive_wb(1'b1, 4'd0, 4'hF, 32'h1234_5678);
        @(posedge clk); #1;
        model_wb(1'b1, 4'd0, 4'hF, 32'h1234_5678);
        chk("pre_rst_ack", {127'b0, wb_ack_o}, 128'd1);
        drive_hw(4'd2, 32'h77);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_ack_drop", {125'b0, wb_ack_o, wb_err_o, hw_gnt}, 128'd0);
        chk("rst_regs_literal", reg_q, {32'hC0DE_0003, 32'h0, 32'h0, 32'hDEAD_0000});
        drop_wb();
        @(posedge clk); #1;
        chk("gnt_in_rst", {127'b0, hw_gnt}, 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("gnt_after_rst", {127'b0, hw_gnt}, 128'd1);
        model_hw(4'd2, 32'h77);
        hw_req = 1'b0;
        @(posedge clk); #1;
        exp_wr = '0;
        chk("gnt_after_rst_1cycle", {127'b0, hw_gnt}, 128'd0);
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
